bf16_reduce_seq: RTL and testbench

Initiator-side sequencer for the bf16 adder interface (bf1_in/bf2_in/op in; bf_out/overflow/underflow/invalid out).
- Accepts a stream of len bf16 values over a valid/ready port and issues one add per element into an external adder instance.
- Waits out the adder's pipeline latency and captures each result as the new running sum.
- Presents the final sum with sticky exception flags on a valid/ready output port.
- Sits between a systolic-array column drain and the adder, supplying operands to the adder and capturing its outputs.

---
 rtl/bf16_pkg.sv | 26 ++
 rtl/bf16_reduce_seq.sv | 117 +++++++++++
 tb/tb_bf16_reduce_seq.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bf16_pkg.sv
// Shared bf16 types and constants for the reduction sequencer and its neighbours.
package bf16_pkg;

   localparam logic [15:0] BF16_ZERO = 16'h0000;

   typedef struct packed {
      logic       sign;
      logic [7:0] exp;
      logic [6:0] frac;
   } bf16_t;

   typedef struct packed {
      logic inv;
      logic unf;
      logic ovf;
   } bf16_flags_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ACCEPT,
      ST_ISSUE,
      ST_WAIT,
      ST_DONE
   } reduce_state_t;

endpackage

// File: rtl/bf16_reduce_seq.sv
// Sequencer that folds a stream of bf16 values through an external adder,
// one add per element, and presents the sum with sticky exception flags.
module bf16_reduce_seq
   import bf16_pkg::*;
#(
   parameter int unsigned LEN_W   = 8,
   parameter int unsigned ADD_LAT = 1
) (
   input  logic             clk,
   input  logic             nRST,
   input  logic             start,
   input  logic [LEN_W-1:0] len,
   output logic             busy,
   input  logic             in_valid,
   input  logic [15:0]      in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [15:0]      out_data,
   output logic [2:0]       out_flags,
   input  logic             out_ready,
   output logic [15:0]      add_a,
   output logic [15:0]      add_b,
   output logic             add_op,
   input  logic [15:0]      add_res,
   input  logic             add_ovf,
   input  logic             add_unf,
   input  logic             add_inv
);

   reduce_state_t    state_q, state_d;
   bf16_t            acc_q, acc_d;
   bf16_t            opnd_q, opnd_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   bf16_flags_t      flags_q, flags_d;
   logic [2:0]       wcnt_q, wcnt_d;

   // State and datapath registers; reset abandons any reduction in flight.
   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         state_q <= ST_IDLE;
         acc_q   <= bf16_t'(BF16_ZERO);
         opnd_q  <= bf16_t'(BF16_ZERO);
         cnt_q   <= '0;
         flags_q <= '0;
         wcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         opnd_q  <= opnd_d;
         cnt_q   <= cnt_d;
         flags_q <= flags_d;
         wcnt_q  <= wcnt_d;
      end
   end

   // Next-state and register updates for the accept/issue/wait loop.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      opnd_d  = opnd_q;
      cnt_d   = cnt_q;
      flags_d = flags_q;
      wcnt_d  = wcnt_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               cnt_d   = len;
               acc_d   = bf16_t'(BF16_ZERO);
               flags_d = '0;
               state_d = (len != '0) ? ST_ACCEPT : ST_DONE;
            end
         end
         ST_ACCEPT: begin
            if (in_valid) begin
               opnd_d  = bf16_t'(in_data);
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            wcnt_d  = 3'(ADD_LAT);
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (wcnt_q == 3'd1) begin
               acc_d   = bf16_t'(add_res);
               flags_d = bf16_flags_t'(flags_q | {add_inv, add_unf, add_ovf});
               cnt_d   = cnt_q - 1'b1;
               state_d = (cnt_q == LEN_W'(1)) ? ST_DONE : ST_ACCEPT;
            end else begin
               wcnt_d = wcnt_q - 3'd1;
            end
         end
         ST_DONE: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs decoded from registered state; adder operands are only driven
   // while an add is in flight so the adder sees no activity otherwise.
   always_comb begin
      busy      = (state_q != ST_IDLE);
      in_ready  = (state_q == ST_ACCEPT);
      out_valid = (state_q == ST_DONE);
      out_data  = (state_q == ST_DONE) ? acc_q : BF16_ZERO;
      out_flags = (state_q == ST_DONE) ? flags_q : '0;
      add_a     = BF16_ZERO;
      add_b     = BF16_ZERO;
      if (state_q == ST_ISSUE || state_q == ST_WAIT) begin
         add_a = acc_q;
         add_b = opnd_q;
      end
      add_op    = 1'b0;
   end

endmodule

// File: tb/tb_bf16_reduce_seq.sv
// Bench for bf16_reduce_seq: behavioural pipelined adder beside the DUT,
// expected sums queued per scenario and compared when out_valid appears.
module tb_bf16_reduce_seq;

   logic clk = 1'b0;
   logic nRST;
   always #5 clk = ~clk;

   // ADD_LAT=1 instance signals
   logic        start, in_valid, out_ready;
   logic [7:0]  len;
   logic [15:0] in_data;
   logic        busy, in_ready, out_valid, add_op;
   logic [15:0] out_data, add_a, add_b, add_res;
   logic [2:0]  out_flags;
   logic        add_ovf, add_unf, add_inv;

   // ADD_LAT=3 instance signals
   logic        start3, in_valid3, out_ready3;
   logic [7:0]  len3;
   logic [15:0] in_data3;
   logic        busy3, in_ready3, out_valid3, add_op3;
   logic [15:0] out_data3, add_a3, add_b3, add_res3;
   logic [2:0]  out_flags3;
   logic        add_ovf3, add_unf3, add_inv3;

   int n_vec = 0;
   int n_err = 0;

   typedef struct packed {
      logic [15:0] d;
      logic [2:0]  f;
   } exp_t;
   exp_t sb[$];

   bf16_reduce_seq #(.LEN_W(8), .ADD_LAT(1)) dut (
      .clk(clk), .nRST(nRST), .start(start), .len(len), .busy(busy),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .out_valid(out_valid), .out_data(out_data), .out_flags(out_flags),
      .out_ready(out_ready), .add_a(add_a), .add_b(add_b), .add_op(add_op),
      .add_res(add_res), .add_ovf(add_ovf), .add_unf(add_unf), .add_inv(add_inv)
   );

   bf16_reduce_seq #(.LEN_W(8), .ADD_LAT(3)) dut3 (
      .clk(clk), .nRST(nRST), .start(start3), .len(len3), .busy(busy3),
      .in_valid(in_valid3), .in_data(in_data3), .in_ready(in_ready3),
      .out_valid(out_valid3), .out_data(out_data3), .out_flags(out_flags3),
      .out_ready(out_ready3), .add_a(add_a3), .add_b(add_b3), .add_op(add_op3),
      .add_res(add_res3), .add_ovf(add_ovf3), .add_unf(add_unf3), .add_inv(add_inv3)
   );

   // ---------------- behavioural bf16 adder ----------------
   function automatic real bf2r(input logic [15:0] x);
      logic [63:0] d;
      if (x[14:0] == 15'd0) d = {x[15], 63'd0};
      else d = {x[15], 11'(x[14:7]) - 11'd127 + 11'd1023, x[6:0], 45'd0};
      return $bitstoreal(d);
   endfunction

   function automatic logic [15:0] r2bf(input real r);
      logic [63:0] d;
      logic [10:0] e;
      d = $realtobits(r);
      if (d[62:0] == 63'd0) return {d[63], 15'd0};
      e = d[62:52] - 11'd1023 + 11'd127;
      return {d[63], e[7:0], d[51:45]};
   endfunction

   // returns {inv, sum}
   function automatic logic [16:0] bf_add(input logic [15:0] a, input logic [15:0] b);
      logic a_nan, b_nan;
      a_nan = (a[14:7] == 8'hFF) && (a[6:0] != 7'd0);
      b_nan = (b[14:7] == 8'hFF) && (b[6:0] != 7'd0);
      if (a_nan || b_nan) return {1'b1, 16'h7FC0};
      return {1'b0, r2bf(bf2r(a) + bf2r(b))};
   endfunction

   logic [16:0] pipe1;
   logic [16:0] pipe3 [3];
   always @(posedge clk) begin
      pipe1    <= bf_add(add_a, add_b);
      pipe3[0] <= bf_add(add_a3, add_b3);
      pipe3[1] <= pipe3[0];
      pipe3[2] <= pipe3[1];
   end
   assign add_res  = pipe1[15:0];
   assign add_inv  = pipe1[16];
   assign add_ovf  = 1'b0;
   assign add_unf  = 1'b0;
   assign add_res3 = pipe3[2][15:0];
   assign add_inv3 = pipe3[2][16];
   assign add_ovf3 = 1'b0;
   assign add_unf3 = 1'b0;

   // ---------------- stimulus driver (ADD_LAT=1 instance) ----------------
   task automatic run1(input int n, input logic [15:0] el [8], input bit tog,
                       output int lat, output logic [15:0] od, output logic [2:0] of,
                       output logic [31:0] rmask, output bit add_act, output bit to);
      int idx;
      idx = 0; rmask = '0; add_act = 1'b0; to = 1'b1; lat = 0; od = '0; of = '0;
      @(negedge clk);
      start = 1'b1; len = 8'(n); in_valid = (n > 0); in_data = el[0];
      for (int c = 1; c < 300; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (add_a != 16'h0 || add_b != 16'h0) add_act = 1'b1;
         if (out_valid) begin
            lat = c; od = out_data; of = out_flags; to = 1'b0; in_valid = 1'b0;
            break;
         end
         in_valid = (idx < n) && (!tog || (c % 2 == 0));
         in_data  = el[(idx < 8) ? idx : 0];
         if (in_ready && c < 32) rmask[c] = 1'b1;
         if (in_valid && in_ready) idx++;
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      nRST = 1'b0;
      start = 0; len = 0; in_valid = 0; in_data = 0; out_ready = 0;
      start3 = 0; len3 = 0; in_valid3 = 0; in_data3 = 0; out_ready3 = 0;
      repeat (3) @(negedge clk);
      n_vec++;
      if ({busy, in_ready, out_valid, add_op} !== 4'b0000) begin
         n_err++; $display("FAIL reset_ctrl: got %b want 0000", {busy, in_ready, out_valid, add_op});
      end
      n_vec++;
      if ({out_data, out_flags, add_a, add_b} !== 51'd0) begin
         n_err++; $display("FAIL reset_data: out_data=%h flags=%b add_a=%h add_b=%h want zeros",
                           out_data, out_flags, add_a, add_b);
      end
      nRST = 1'b1;
      @(negedge clk);
      n_vec++;
      if (busy !== 1'b0 || busy3 !== 1'b0) begin
         n_err++; $display("FAIL reset_release_busy: got %b/%b want 0/0", busy, busy3);
      end
   endtask

   task automatic consume_and_check_idle(input string nm);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      n_vec++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         n_err++; $display("FAIL %s_idle: busy=%b out_valid=%b want 0/0", nm, busy, out_valid);
      end
   endtask

   task automatic test_two();
      logic [15:0] el [8];
      int lat; logic [15:0] od; logic [2:0] of; logic [31:0] rm; bit act, to; exp_t e;
      el = '{16'h3F80, 16'h4000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
      sb.push_back('{d: 16'h4040, f: 3'b000});
      run1(2, el, 1'b0, lat, od, of, rm, act, to);
      e = sb.pop_front();
      n_vec++;
      if (to) begin n_err++; $display("FAIL two_timeout: no out_valid within budget"); end
      n_vec++;
      if ({od, of} !== {e.d, e.f}) begin
         n_err++; $display("FAIL two_result: got %h/%b want %h/%b", od, of, e.d, e.f);
      end
      n_vec++;
      if (lat !== 7) begin n_err++; $display("FAIL two_latency: got %0d want 7", lat); end
      n_vec++;
      if (rm !== 32'h12) begin n_err++; $display("FAIL two_in_ready_cycles: got %h want 00000012", rm); end
      consume_and_check_idle("two");
   endtask

   task automatic test_toggle();
      logic [15:0] el [8];
      int lat; logic [15:0] od; logic [2:0] of; logic [31:0] rm; bit act, to; exp_t e;
      el = '{16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80, 16'h0, 16'h0, 16'h0, 16'h0};
      sb.push_back('{d: 16'h4080, f: 3'b000});
      run1(4, el, 1'b1, lat, od, of, rm, act, to);
      e = sb.pop_front();
      n_vec++;
      if (to || {od, of} !== {e.d, e.f}) begin
         n_err++; $display("FAIL toggle_result: timeout=%b got %h/%b want %h/%b", to, od, of, e.d, e.f);
      end
      consume_and_check_idle("toggle");
   endtask

   task automatic test_zero_len();
      logic [15:0] el [8];
      int lat; logic [15:0] od; logic [2:0] of; logic [31:0] rm; bit act, to; exp_t e;
      el = '{default: 16'h3F80};
      sb.push_back('{d: 16'h0000, f: 3'b000});
      run1(0, el, 1'b0, lat, od, of, rm, act, to);
      e = sb.pop_front();
      n_vec++;
      if (to || lat !== 1) begin n_err++; $display("FAIL zero_latency: timeout=%b got %0d want 1", to, lat); end
      n_vec++;
      if ({od, of} !== {e.d, e.f}) begin
         n_err++; $display("FAIL zero_result: got %h/%b want %h/%b", od, of, e.d, e.f);
      end
      n_vec++;
      if (act !== 1'b0 || rm !== 32'h0) begin
         n_err++; $display("FAIL zero_activity: add_act=%b in_ready_mask=%h want 0/0", act, rm);
      end
      consume_and_check_idle("zero");
   endtask

   task automatic test_nan_hold();
      logic [15:0] el [8];
      int lat; logic [15:0] od; logic [2:0] of; logic [31:0] rm; bit act, to; exp_t e;
      el = '{16'h3F80, 16'h7FC0, 16'h3F80, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
      sb.push_back('{d: 16'h7FC0, f: 3'b100});
      run1(3, el, 1'b0, lat, od, of, rm, act, to);
      e = sb.pop_front();
      n_vec++;
      if (to || {od, of} !== {e.d, e.f}) begin
         n_err++; $display("FAIL nan_result: timeout=%b got %h/%b want %h/%b", to, od, of, e.d, e.f);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_vec++;
         if ({out_valid, out_data, out_flags} !== {1'b1, e.d, e.f}) begin
            n_err++; $display("FAIL nan_hold_%0d: got %b/%h/%b want 1/%h/%b",
                              i, out_valid, out_data, out_flags, e.d, e.f);
         end
      end
      // start coinciding with the output handshake must not launch a reduction
      out_ready = 1'b1; start = 1'b1; len = 8'd1;
      @(negedge clk);
      out_ready = 1'b0; start = 1'b0;
      n_vec++;
      if (busy !== 1'b0 || out_valid !== 1'b0) begin
         n_err++; $display("FAIL nan_idle_start_ignored: busy=%b out_valid=%b want 0/0", busy, out_valid);
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] el [8];
      int lat; logic [15:0] od; logic [2:0] of; logic [31:0] rm; bit act, to; exp_t e;
      @(negedge clk);
      start = 1'b1; len = 8'd3; in_valid = 1'b1; in_data = 16'h3F80;
      repeat (6) begin
         @(negedge clk);
         start = 1'b0;
      end
      // cycle 6 is the WAIT of the second element
      n_vec++;
      if (busy !== 1'b1 || add_b !== 16'h3F80 || add_a !== 16'h3F80) begin
         n_err++; $display("FAIL mid_pre_reset: busy=%b add_a=%h add_b=%h want 1/3f80/3f80", busy, add_a, add_b);
      end
      nRST = 1'b0; in_valid = 1'b0;
      #1;
      n_vec++;
      if ({busy, in_ready, out_valid, add_op, out_data, out_flags, add_a, add_b} !== 55'd0) begin
         n_err++; $display("FAIL mid_reset_outputs: busy=%b in_ready=%b out_valid=%b out_data=%h add_a=%h add_b=%h want zeros",
                           busy, in_ready, out_valid, out_data, add_a, add_b);
      end
      @(negedge clk);
      nRST = 1'b1;
      el = '{16'h3FC0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
      sb.push_back('{d: 16'h3FC0, f: 3'b000});
      run1(1, el, 1'b0, lat, od, of, rm, act, to);
      e = sb.pop_front();
      n_vec++;
      if (to || {od, of} !== {e.d, e.f} || lat !== 4) begin
         n_err++; $display("FAIL mid_restart: timeout=%b got %h/%b lat %0d want %h/%b lat 4",
                           to, od, of, lat, e.d, e.f);
      end
      consume_and_check_idle("mid");
   endtask

   task automatic test_lat3();
      int run_len, lat;
      int runs[$];
      logic [15:0] ra;
      bit unstable, to;
      logic [15:0] od; logic [2:0] of; exp_t e;
      run_len = 0; unstable = 1'b0; to = 1'b1; lat = 0; ra = '0; od = '0; of = '0;
      sb.push_back('{d: 16'h3F80, f: 3'b000});
      @(negedge clk);
      start3 = 1'b1; len3 = 8'd2; in_valid3 = 1'b1; in_data3 = 16'h3F00;
      for (int c = 1; c < 200; c++) begin
         @(negedge clk);
         start3 = (c == 3 || c == 6 || c == 9);
         len3   = start3 ? 8'd5 : 8'd2;
         if (add_b3 == 16'h3F00) begin
            if (run_len == 0) ra = add_a3;
            else if (add_a3 !== ra) unstable = 1'b1;
            run_len++;
         end else if (run_len != 0) begin
            runs.push_back(run_len);
            run_len = 0;
         end
         if (out_valid3) begin
            lat = c; od = out_data3; of = out_flags3; to = 1'b0;
            break;
         end
      end
      start3 = 1'b0; in_valid3 = 1'b0;
      e = sb.pop_front();
      n_vec++;
      if (to || {od, of} !== {e.d, e.f}) begin
         n_err++; $display("FAIL lat3_result: timeout=%b got %h/%b want %h/%b", to, od, of, e.d, e.f);
      end
      n_vec++;
      if (lat !== 11) begin n_err++; $display("FAIL lat3_latency: got %0d want 11", lat); end
      n_vec++;
      if (runs.size() != 2 || unstable) begin
         n_err++; $display("FAIL lat3_operand_runs: runs=%0d unstable=%b want 2/0", runs.size(), unstable);
      end else begin
         for (int i = 0; i < 2; i++) begin
            n_vec++;
            if (runs[i] != 4) begin
               n_err++; $display("FAIL lat3_run_len_%0d: got %0d want 4", i, runs[i]);
            end
         end
      end
      out_ready3 = 1'b1;
      @(negedge clk);
      out_ready3 = 1'b0;
      n_vec++;
      if (busy3 !== 1'b0) begin n_err++; $display("FAIL lat3_idle: busy=%b want 0", busy3); end
   endtask

   initial begin
      test_reset();
      test_two();
      test_toggle();
      test_zero_len();
      test_nan_hold();
      test_reset_mid();
      test_lat3();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // hard stop so the bench can never hang
   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
